// File: rtl/d_cache_if.sv
// d_cache_if: CPU memory-stage and data-memory signals of the data cache.
// slave is the cache's view; master is the surrounding CPU/memory environment.
interface d_cache_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [7:0]  cpu_addr;
  logic [15:0] cpu_wdata;
  logic [15:0] cpu_rdata;
  logic        cpu_stall;
  logic        mem_req;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
    output cpu_rdata, cpu_stall, mem_req, mem_we, mem_addr, mem_wdata
  );
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
    input  cpu_rdata, cpu_stall, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/d_cache.sv
// d_cache: direct-mapped, write-through, write-no-allocate data cache, one 16-bit word per line.
// Defining DCACHE_STATS_EN adds saturating hit_count/miss_count ports.
module d_cache #(
  parameter int INDEX_BITS = 4
) (
  input  logic        clock,
  input  logic        reset,
  d_cache_if.slave    bus
`ifdef DCACHE_STATS_EN
  ,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
`endif
);
  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_BITS = 8 - INDEX_BITS;
  typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;
  state_t                state_q, state_d;
  logic [LINES-1:0]      valid_q, valid_d;
  logic [TAG_BITS-1:0]   tag_q [LINES];
  logic [TAG_BITS-1:0]   tag_d [LINES];
  logic [15:0]           data_q [LINES];
  logic [15:0]           data_d [LINES];
  logic [15:0]           fill_q, fill_d;
  logic                  ld_q, ld_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q, mem_we_d;
  logic [7:0]            mem_addr_q, mem_addr_d;
  logic [15:0]           mem_wdata_q, mem_wdata_d;
  logic [INDEX_BITS-1:0] idx;
  logic [TAG_BITS-1:0]   tag;
  logic                  hit;
  assign idx = bus.cpu_addr[INDEX_BITS-1:0];
  assign tag = bus.cpu_addr[7:INDEX_BITS];
  assign hit = valid_q[idx] && (tag_q[idx] == tag);
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  always_comb begin
    state_d       = state_q;
    valid_d       = valid_q;
    tag_d         = tag_q;
    data_d        = data_q;
    fill_d        = fill_q;
    ld_d          = ld_q;
    mem_req_d     = mem_req_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    bus.cpu_stall = 1'b0;
    bus.cpu_rdata = 16'h0000;
    case (state_q)
      IDLE: begin
        if (bus.cpu_req && bus.cpu_we) begin
          bus.cpu_stall = 1'b1;
          state_d       = WRITE;
          mem_req_d     = 1'b1;
          mem_we_d      = 1'b1;
          mem_addr_d    = bus.cpu_addr;
          mem_wdata_d   = bus.cpu_wdata;
        end else if (bus.cpu_req && hit) begin
          bus.cpu_rdata = data_q[idx];
        end else if (bus.cpu_req) begin
          bus.cpu_stall = 1'b1;
          state_d       = FILL;
          mem_req_d     = 1'b1;
          mem_we_d      = 1'b0;
          mem_addr_d    = bus.cpu_addr;
        end
      end
      FILL: begin
        bus.cpu_stall = 1'b1;
        if (bus.mem_ack) begin
          valid_d[idx] = 1'b1;
          tag_d[idx]   = tag;
          data_d[idx]  = bus.mem_rdata;
          fill_d       = bus.mem_rdata;
          ld_d         = 1'b1;
          mem_req_d    = 1'b0;
          state_d      = DONE;
        end
      end
      WRITE: begin
        bus.cpu_stall = 1'b1;
        if (bus.mem_ack) begin
          data_d[idx] = hit ? bus.cpu_wdata : data_q[idx];
          ld_d        = 1'b0;
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          state_d     = DONE;
        end
      end
      DONE: begin
        bus.cpu_rdata = ld_q ? fill_q : 16'h0000;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      tag_q       <= '{default: '0};
      data_q      <= '{default: '0};
      fill_q      <= '0;
      ld_q        <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      tag_q       <= tag_d;
      data_q      <= data_d;
      fill_q      <= fill_d;
      ld_q        <= ld_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end
`ifdef DCACHE_STATS_EN
  logic        rd_hit, rd_miss;
  logic [15:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;
  assign rd_hit  = state_q == IDLE && bus.cpu_req && !bus.cpu_we && hit;
  assign rd_miss = state_q == IDLE && bus.cpu_req && !bus.cpu_we && !hit;
  always_comb begin
    hit_cnt_d  = hit_cnt_q + 16'(rd_hit && hit_cnt_q != 16'hFFFF);
    miss_cnt_d = miss_cnt_q + 16'(rd_miss && miss_cnt_q != 16'hFFFF);
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end
  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif
endmodule

// File: tb/tb_d_cache.sv
// tb_d_cache: directed loads/stores against a delayed-ack memory model; a negedge monitor
// retires each CPU access and compares it with the expectation queued by the driver.
module tb_d_cache;
  logic clock = 1'b0;
  logic reset = 1'b1;
  d_cache_if bus ();
`ifdef DCACHE_STATS_EN
  logic [15:0] hit_count, miss_count;
  d_cache dut (.clock(clock), .reset(reset), .bus(bus), .hit_count(hit_count), .miss_count(miss_count));
`else
  d_cache dut (.clock(clock), .reset(reset), .bus(bus));
`endif
  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] rdata;
    int          stalls;
    logic        mem_txn;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
  } exp_t;
  exp_t exp_q[$];

  int   n_cmp = 0;
  int   n_bad = 0;
  int   ack_delay = 1;
  logic inj_ack = 1'b0;
  logic mon_en = 1'b1;
  logic [15:0] tb_mem [256];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // memory model: ack ack_delay cycles into a transaction, or once on request while idle
  initial begin
    int w = 0;
    bus.mem_ack = 1'b0;
    bus.mem_rdata = 16'h0000;
    forever begin
      @(negedge clock);
      if (bus.mem_ack) begin
        bus.mem_ack = 1'b0;
        w = 0;
      end else if (inj_ack) begin
        bus.mem_ack = 1'b1;
        bus.mem_rdata = 16'hDEAD;
        inj_ack = 1'b0;
      end else if (bus.mem_req && !reset) begin
        w++;
        if (w == ack_delay) begin
          bus.mem_ack = 1'b1;
          if (bus.mem_we) tb_mem[bus.mem_addr] = bus.mem_wdata;
          else bus.mem_rdata = tb_mem[bus.mem_addr];
        end
      end else w = 0;
    end
  end

  // monitor: counts stalled cycles, captures the memory transaction, retires on stall release
  initial begin
    int   stalls = 0;
    logic seen = 1'b0;
    logic c_we = 1'b0;
    logic [7:0]  c_addr = '0;
    logic [15:0] c_wdata = '0;
    exp_t e;
    forever begin
      @(negedge clock);
      if (!mon_en || reset || !bus.cpu_req) begin
        stalls = 0;
        seen = 1'b0;
      end else begin
        if (bus.mem_req && !seen) begin
          seen = 1'b1;
          c_we = bus.mem_we;
          c_addr = bus.mem_addr;
          c_wdata = bus.mem_wdata;
        end
        if (bus.cpu_stall) stalls++;
        else if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL retire: unexpected completion at %h", bus.cpu_addr);
        end else begin
          e = exp_q.pop_front();
          check("rdata", bus.cpu_rdata, e.rdata);
          check("stall_cycles", 16'(stalls), 16'(e.stalls));
          check("mem_txn", {15'b0, seen}, {15'b0, e.mem_txn});
          if (e.mem_txn) begin
            check("mem_we", {15'b0, c_we}, {15'b0, e.mem_we});
            check("mem_addr", {8'b0, c_addr}, {8'b0, e.mem_addr});
            if (e.mem_we) check("mem_wdata", c_wdata, e.mem_wdata);
          end
          stalls = 0;
          seen = 1'b0;
        end
      end
    end
  end

  task automatic access(input logic we, input logic [7:0] addr, input logic [15:0] wdata,
                        input int dly, input logic [15:0] rdata, input int stalls, input logic txn);
    logic done = 1'b0;
    exp_q.push_back('{rdata, stalls, txn, we, addr, wdata});
    ack_delay = dly;
    bus.cpu_req = 1'b1;
    bus.cpu_we = we;
    bus.cpu_addr = addr;
    bus.cpu_wdata = wdata;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clock);
      done = !bus.cpu_stall;
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout: access to %h never released stall", addr);
    end
    @(posedge clock);
    #1;
    bus.cpu_req = 1'b0;
    bus.cpu_we = 1'b0;
    @(posedge clock);
    #1;
  endtask

  initial begin
    foreach (tb_mem[i]) tb_mem[i] = 16'h0000;
    tb_mem[8'h23] = 16'hBEEF;
    tb_mem[8'h13] = 16'hCAFE;
    tb_mem[8'h40] = 16'h5555;
    tb_mem[8'hFF] = 16'hA5A5;
    bus.cpu_req = 1'b0;
    bus.cpu_we = 1'b0;
    bus.cpu_addr = '0;
    bus.cpu_wdata = '0;
    repeat (2) @(negedge clock);
    check("rst_mem_req", {15'b0, bus.mem_req}, 16'h0);
    check("rst_mem_we", {15'b0, bus.mem_we}, 16'h0);
    check("rst_mem_addr", {8'b0, bus.mem_addr}, 16'h0);
    check("rst_mem_wdata", bus.mem_wdata, 16'h0);
    check("rst_stall", {15'b0, bus.cpu_stall}, 16'h0);
    check("rst_rdata", bus.cpu_rdata, 16'h0);
    @(posedge clock);
    #1 reset = 1'b0;
    @(posedge clock);
    #1;
    access(0, 8'h23, 0, 3, 16'hBEEF, 4, 1);
    access(0, 8'h23, 0, 1, 16'hBEEF, 0, 0);
`ifdef DCACHE_STATS_EN
    check("hit_count", hit_count, 16'd1);
    check("miss_count", miss_count, 16'd1);
`endif
    access(0, 8'h13, 0, 1, 16'hCAFE, 2, 1);
    access(0, 8'h23, 0, 1, 16'hBEEF, 2, 1);
    access(0, 8'h13, 0, 1, 16'hCAFE, 2, 1);
    access(1, 8'h13, 16'h1234, 1, 16'h0000, 2, 1);
    access(0, 8'h13, 0, 1, 16'h1234, 0, 0);
    access(1, 8'h40, 16'h7777, 2, 16'h0000, 3, 1);
    access(0, 8'h40, 0, 1, 16'h7777, 2, 1);
    inj_ack = 1'b1;
    repeat (3) @(negedge clock);
    check("idle_ack_mem_req", {15'b0, bus.mem_req}, 16'h0);
    check("idle_ack_stall", {15'b0, bus.cpu_stall}, 16'h0);
    @(posedge clock);
    #1;
    access(0, 8'h13, 0, 1, 16'h1234, 0, 0);
    access(0, 8'h40, 0, 1, 16'h7777, 0, 0);
    mon_en = 1'b0;
    ack_delay = 20;
    bus.cpu_req = 1'b1;
    bus.cpu_addr = 8'hFF;
    repeat (3) @(negedge clock);
    check("fill_mem_req", {15'b0, bus.mem_req}, 16'h1);
    #2 reset = 1'b1;
    bus.cpu_req = 1'b0;
    #1;
    check("rst_fill_mem_req", {15'b0, bus.mem_req}, 16'h0);
    check("rst_fill_stall", {15'b0, bus.cpu_stall}, 16'h0);
    @(posedge clock);
    #1 reset = 1'b0;
    mon_en = 1'b1;
    @(posedge clock);
    #1;
    access(0, 8'hFF, 0, 1, 16'hA5A5, 2, 1);
    access(0, 8'hFF, 0, 1, 16'hA5A5, 0, 0);
    access(0, 8'h23, 0, 1, 16'hBEEF, 2, 1);
    repeat (2) @(posedge clock);
    check("queue_drained", 16'(exp_q.size()), 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
